// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the serial sequence detector family.
package seq_det_pkg;

    localparam int SEQ_MAX_W = 32;
    localparam logic [3:0] SEQ_DEF_PAT = 4'b1100;

    // Ceiling log2. Returns the number of bits needed to index value-1.
    function automatic int clog2_w(input int value);
        int bits;
        int rem;
        bits = 0;
        rem  = value - 1;
        while (rem > 0) begin
            bits = bits + 1;
            rem  = rem >> 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/seq_detect_param_sat_counter.sv
// Increment-with-saturation counter. It is shared with other counting blocks.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seq_detect_param.sv
// Parametrised serial sequence detector. It has a run-time reloadable pattern,
// overlapping or restart matching, a one-cycle hit pulse and a saturating hit count.
module seq_detect_param
    import seq_det_pkg::*;
#(
    parameter int             W       = 4,
    parameter logic [W-1:0]   PATTERN = W'(SEQ_DEF_PAT),
    parameter int             OVERLAP = 1,
    parameter int             CNT_W   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic                   in,
    input  logic                   load,
    input  logic [W-1:0]           load_pat,
    output logic                   out,
    output logic [CNT_W-1:0]       count,
    output logic [$clog2(W+1)-1:0] busy_len
);

    localparam int                FILL_W = clog2_w(W + 1);
    localparam logic [FILL_W-1:0] FULL   = FILL_W'(W);
    localparam logic [FILL_W-1:0] ONE    = FILL_W'(1);

    logic [W-1:0]      pat;
    logic [W-1:0]      hist;
    logic [FILL_W-1:0] fill;
    logic [W-1:0]      nh;
    logic [FILL_W-1:0] nf;
    logic              hit;

    // The window shifts per valid bit, not per cycle. Idle gaps leave a match in progress intact.
    always_comb begin
        nh  = {hist[W-2:0], in};
        nf  = (fill == FULL) ? FULL : fill + ONE;
        hit = (nf == FULL) && (nh == pat);
    end

    // NOTE: state registers use non-blocking assignments so that every read in this block sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat  <= PATTERN;
            hist <= '0;
            fill <= '0;
            out  <= 1'b0;
        end else if (load) begin
            pat  <= load_pat;
            hist <= '0;
            fill <= '0;
            out  <= 1'b0;
        end else if (in_valid) begin
            hist <= nh;
            out  <= hit;
            fill <= (hit && (OVERLAP == 0)) ? '0 : nf;
        end else begin
            out  <= 1'b0;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_count (
        .clk   (clk),
        .reset (reset),
        .inc   (in_valid && !load && hit),
        .q     (count)
    );

    assign busy_len = fill;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: defaults, no-overlap, saturating count and reload variants.
module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic       din = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_pat = 4'b0000;

    logic       out_d,  out_n,  out_s;
    logic [7:0] count_d, count_n;
    logic [1:0] count_s;
    logic [2:0] busy_d, busy_n, busy_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Defaults: W=4, 1100, overlap on, 8-bit count.
    seq_detect_param u_def (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in(din), .load(load),
        .load_pat(load_pat), .out(out_d), .count(count_d), .busy_len(busy_d)
    );

    seq_detect_param #(.OVERLAP(0)) u_novl (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in(din), .load(load),
        .load_pat(load_pat), .out(out_n), .count(count_n), .busy_len(busy_n)
    );

    seq_detect_param #(.PATTERN(4'b1111), .CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in(din), .load(load),
        .load_pat(load_pat), .out(out_s), .count(count_s), .busy_len(busy_s)
    );

    // Drive inputs on the falling edge and return 1 time unit after the next rising edge.
    task automatic step(input logic v, input logic b, input logic ld, input logic [3:0] lp);
        @(negedge clk);
        in_valid = v;
        din      = b;
        load     = ld;
        load_pat = lp;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        load     = 1'b0;
        reset    = 1'b1;
        #2;
        reset    = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (out_d !== 1'b0 || count_d !== 8'd0 || busy_d !== 3'd0) begin
            $display("FAIL reset_state: out=%b count=%0d busy=%0d, required 0/0/0", out_d, count_d, busy_d);
            n_fail++;
        end
    endtask

    task automatic test_default_stream();
        logic [9:0] bits;
        logic [9:0] hits;
        bits = 10'b1100110011;
        hits = 10'b0001000100;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, bits[9-i], 1'b0, 4'b0000);
            n_checks++;
            if (out_d !== hits[9-i]) begin
                $display("FAIL default_out bit%0d: got %b, required %b", i + 1, out_d, hits[9-i]);
                n_fail++;
            end
            n_checks++;
            if (busy_d !== ((i < 4) ? 3'(i + 1) : 3'd4)) begin
                $display("FAIL default_busy bit%0d: got %0d, required %0d", i + 1, busy_d, (i < 4) ? i + 1 : 4);
                n_fail++;
            end
        end
        n_checks++;
        if (count_d !== 8'd2) begin
            $display("FAIL default_count: got %0d, required 2", count_d);
            n_fail++;
        end
    endtask

    task automatic test_load_overlap();
        logic [5:0] bits;
        logic [5:0] hits_d;
        logic [5:0] hits_n;
        bits   = 6'b101010;
        hits_d = 6'b000101;
        hits_n = 6'b000100;
        do_reset();
        // Load with in_valid high: the data bit must be ignored on that edge.
        step(1'b1, 1'b1, 1'b1, 4'b1010);
        n_checks++;
        if (busy_d !== 3'd0 || out_d !== 1'b0) begin
            $display("FAIL load_clears: busy=%0d out=%b, required 0/0", busy_d, out_d);
            n_fail++;
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b1, bits[5-i], 1'b0, 4'b0000);
            n_checks++;
            if (out_d !== hits_d[5-i]) begin
                $display("FAIL ovl_out bit%0d: got %b, required %b", i + 1, out_d, hits_d[5-i]);
                n_fail++;
            end
            n_checks++;
            if (out_n !== hits_n[5-i]) begin
                $display("FAIL novl_out bit%0d: got %b, required %b", i + 1, out_n, hits_n[5-i]);
                n_fail++;
            end
            if (i == 3) begin
                n_checks++;
                if (busy_n !== 3'd0) begin
                    $display("FAIL novl_busy_after_hit: got %0d, required 0", busy_n);
                    n_fail++;
                end
            end
        end
        n_checks++;
        if (count_d !== 8'd2 || count_n !== 8'd1) begin
            $display("FAIL load_counts: ovl=%0d novl=%0d, required 2/1", count_d, count_n);
            n_fail++;
        end
        n_checks++;
        if (busy_n !== 3'd2) begin
            $display("FAIL novl_busy_end: got %0d, required 2", busy_n);
            n_fail++;
        end
    endtask

    task automatic test_gaps();
        logic [3:0] bits;
        bits = 4'b1100;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, bits[3-i], 1'b0, 4'b0000);
            n_checks++;
            if (out_d !== (i == 3)) begin
                $display("FAIL gap_out bit%0d: got %b, required %b", i + 1, out_d, i == 3);
                n_fail++;
            end
            for (int g = 0; g < 3; g++) begin
                step(1'b0, ~bits[3-i], 1'b0, 4'b0000);
                n_checks++;
                if (out_d !== 1'b0 || busy_d !== 3'(i + 1)) begin
                    $display("FAIL gap_idle bit%0d gap%0d: out=%b busy=%0d, required 0/%0d", i + 1, g, out_d, busy_d, i + 1);
                    n_fail++;
                end
            end
        end
        n_checks++;
        if (count_d !== 8'd1) begin
            $display("FAIL gap_count: got %0d, required 1", count_d);
            n_fail++;
        end
    endtask

    task automatic test_reload_mid_match();
        logic [6:0] pre;
        logic [3:0] post;
        pre  = 7'b1100110;
        post = 4'b0011;
        do_reset();
        for (int i = 0; i < 7; i++) step(1'b1, pre[6-i], 1'b0, 4'b0000);
        n_checks++;
        if (count_d !== 8'd1) begin
            $display("FAIL reload_pre_count: got %0d, required 1", count_d);
            n_fail++;
        end
        step(1'b0, 1'b0, 1'b1, 4'b0011);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, post[3-i], 1'b0, 4'b0000);
            n_checks++;
            if (out_d !== (i == 3)) begin
                $display("FAIL reload_out bit%0d: got %b, required %b", i + 1, out_d, i == 3);
                n_fail++;
            end
        end
        n_checks++;
        if (count_d !== 8'd2) begin
            $display("FAIL reload_count: got %0d, required 2", count_d);
            n_fail++;
        end
    endtask

    task automatic test_saturation();
        int pulses;
        pulses = 0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, 1'b0, 4'b0000);
            if (out_s === 1'b1) pulses++;
            if (i >= 3) begin
                n_checks++;
                if (count_s !== ((i >= 5) ? 2'd3 : 2'(i - 2))) begin
                    $display("FAIL sat_count bit%0d: got %0d, required %0d", i + 1, count_s, (i >= 5) ? 3 : i - 2);
                    n_fail++;
                end
            end
        end
        n_checks++;
        if (pulses != 5) begin
            $display("FAIL sat_pulses: got %0d, required 5", pulses);
            n_fail++;
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] full;
        full = 4'b1100;
        do_reset();
        step(1'b1, 1'b1, 1'b0, 4'b0000);
        step(1'b1, 1'b1, 1'b0, 4'b0000);
        step(1'b1, 1'b0, 1'b0, 4'b0000);
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (busy_d !== 3'd0 || out_d !== 1'b0 || count_d !== 8'd0) begin
            $display("FAIL async_partial: busy=%0d out=%b count=%0d, required 0/0/0", busy_d, out_d, count_d);
            n_fail++;
        end
        #1 reset = 1'b0;
        step(1'b1, 1'b0, 1'b0, 4'b0000);
        n_checks++;
        if (out_d !== 1'b0) begin
            $display("FAIL async_lost_match: got %b, required 0", out_d);
            n_fail++;
        end
        for (int i = 0; i < 4; i++) step(1'b1, full[3-i], 1'b0, 4'b0000);
        n_checks++;
        if (out_d !== 1'b1 || count_d !== 8'd1) begin
            $display("FAIL async_rematch: out=%b count=%0d, required 1/1", out_d, count_d);
            n_fail++;
        end
        // Reset during the hit cycle must drop the pulse before the next edge.
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (out_d !== 1'b0 || count_d !== 8'd0 || busy_d !== 3'd0) begin
            $display("FAIL async_drop_pulse: out=%b count=%0d busy=%0d, required 0/0/0", out_d, count_d, busy_d);
            n_fail++;
        end
        #1 reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_default_stream();
        test_load_overlap();
        test_gaps();
        test_reload_mid_match();
        test_saturation();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised serial sequence detector for single-bit input streams. It detects a W-bit pattern that is set at elaboration and can be reloaded at run time, with overlapping or non-overlapping matching. It emits a one-cycle hit pulse and keeps a saturating hit count. It is the general replacement for the fixed-pattern `fsm` detector and sits on the same one-bit `in` stream, with an added qualifier.

## Interface
- `W`, default 4: pattern length in bits; legal range 2..32.
- `PATTERN`, default 4'b1100: pattern loaded at reset. MSB is the first bit received.
- `OVERLAP`, default 1: 1 means the bits of a hit may start the next match; 0 means matching restarts empty after each hit.
- `CNT_W`, default 8: hit counter width.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  `in` is sampled only when this is 1.
- `in`  in  1  serial data bit.
- `load`  in  1  replace the active pattern with `load_pat`.
- `load_pat`  in  W  new pattern, MSB first.
- `out`  out  1  registered hit pulse.
- `count`  out  CNT_W  saturating number of hits.
- `busy_len`  out  $clog2(W+1)  valid bits currently in the history window.

## Operation
- State registers:
  - `pat[W-1:0]`
  - `hist[W-1:0]`, holding the most recent bit in the LSB
  - `fill`, saturating at W
  - `out`
  - `count`
- Reset, asynchronous: `pat`=PATTERN, `hist`=0, `fill`=0, `out`=0, `count`=0, so `busy_len`=0.
- Priority per edge: `load` > `in_valid` > idle.
- `load`=1:
  - `pat`<=`load_pat`, `hist`<=0, `fill`<=0, `out`<=0.
  - `in`/`in_valid` are ignored that cycle.
  - `count` is preserved.
- `in_valid`=1, `load`=0:
  - nh = {hist[W-2:0], in}; nf = min(fill+1, W).
  - hit = (nf==W) && (nh==pat).
  - `hist`<=nh; `out`<=hit; `count`<=count+1 on hit, saturating at 2^CNT_W-1.
  - `fill`<=nf, except when hit && OVERLAP==0, where `fill`<=0.
- Idle (`in_valid`=0, `load`=0): `hist`, `fill`, `count` hold; `out`<=0.
- `busy_len` = `fill`, driven directly from the register.
- No pattern value is illegal: all-0 and all-1 are valid. A run of W+k identical bits gives k+1 hits with overlap on, and floor((W+k)/W) hits with overlap off.

## Timing
- Latency: the final pattern bit is sampled at edge E; `out` is 1 from E until edge E+1. It is never wider than one cycle, even on back-to-back hits with overlap on: consecutive hits give consecutive 1s, one per valid bit.
- `count` updates at the same edge E as `out`.
- A pattern loaded at edge L applies to bits sampled at L+1 onward; the first possible hit is at L+W.
- `reset` asserted mid-stream clears everything immediately, without waiting for `clk`. Any partial match is lost, and `out` drops within the same cycle.
- Gaps in `in_valid` do not break a match in progress. History is bit-indexed, not cycle-indexed.

## Structure
- Shared package `seq_det_pkg` holds:
  - function `clog2_w`
  - constant `SEQ_MAX_W`=32
  - localparam default pattern `SEQ_DEF_PAT`=4'b1100
- One natural sub-module, `sat_counter` (parameter CNT_W; ports clk, reset, inc, q). It implements increment-with-saturation and is reused by other counting blocks.
- The history/fill/compare logic stays in the top module.

## Test plan
- Defaults (W=4, 1100, OVERLAP=1), `in_valid`=1, stream 1,1,0,0,1,1,0,0,1,1 → `out` pulses after bits 4 and 8 only; final `count`=2; `busy_len` ramps 1,2,3,4 then stays at 4.
- `load_pat`=4'b1010, stream 1,0,1,0,1,0 → hits at bits 4 and 6 (`count`=2). Same stimulus with OVERLAP=0 → one hit at bit 4; `busy_len`=0 immediately after the hit, 2 at stream end.
- Defaults, stream 1,1,0,0 with `in_valid` dropped for 3 cycles between each bit → exactly one `out` pulse, on the edge sampling the last 0; `out`=0 during all idle cycles.
- Stream 1,1,0 then `load`=1 with `load_pat`=4'b0011, then 0,0,1,1 → no hit from the old partial match; a hit on the 4th new bit; `count` keeps its earlier value +1.
- CNT_W=2, pattern 1111, 8 ones with OVERLAP=1 → 5 `out` pulses; `count` sequence 1,2,3,3,3.
- `reset` pulsed asynchronously between edges after 1,1,0 → all outputs 0 before the next edge; a following 0 alone gives no hit; a full 1,1,0,0 gives a hit.
